// File: rtl/ram_ctrl.sv
// ram_ctrl: byte-wide memory controller and arbiter between the instruction
// cache (line fills) and the MEM stage (byte loads/stores). It owns a
// single-port synchronous RAM with one-cycle read latency and locks the bus
// to the current owner until that owner drops its request.
module ram_ctrl #(
  parameter int unsigned ADDR_W = 17  // must be below 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_ICACHE_i,
  input  logic [31:0]       addr_ICACHE_i,
  output logic              stl_ICACHE_o,
  input  logic              re_MEM_i,
  input  logic              we_MEM_i,
  input  logic [31:0]       addr_MEM_i,
  input  logic [7:0]        data_MEM_i,
  output logic              stl_MEM_o,
  output logic [7:0]        data_RAM_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_din_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_dout_i
);

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_ICACHE = 2'd1,
    OWN_MEM    = 2'd2
  } owner_t;

  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   w_req_i;
  logic   w_req_m;
  logic   w_unused;

  assign w_req_i    = re_ICACHE_i;
  assign w_req_m    = re_MEM_i | we_MEM_i;
  assign data_RAM_o = mem_dout_i;

  // Address bits above the RAM size are deliberately ignored.
  assign w_unused = ^{addr_ICACHE_i[31:ADDR_W], addr_MEM_i[31:ADDR_W]};

  // Owner register; reset (also mid-burst) returns the bus to idle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation order cannot change the result.
    if (rst) begin
      r_owner <= OWN_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Next owner (lock, then MEM-first arbitration), stalls and RAM drive.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_owner_nxt  = OWN_IDLE;
    stl_ICACHE_o = w_req_i;
    stl_MEM_o    = w_req_m;
    mem_a_o      = '0;
    mem_wr_o     = 1'b0;
    mem_din_o    = '0;

    // The owner keeps the bus while it still requests; a line fill is never
    // preempted. Otherwise MEM wins because it is older in the pipeline.
    if ((r_owner == OWN_ICACHE && w_req_i) || (r_owner == OWN_MEM && w_req_m)) begin
      w_owner_nxt = r_owner;
    end else if (w_req_m) begin
      w_owner_nxt = OWN_MEM;
    end else if (w_req_i) begin
      w_owner_nxt = OWN_ICACHE;
    end

    // While reset is held the owner register may still show a stale grant, so
    // the stalls mirror the requests and the RAM is left untouched.
    if (!rst) begin
      stl_ICACHE_o = w_req_i & (r_owner != OWN_ICACHE);
      stl_MEM_o    = w_req_m & (r_owner != OWN_MEM);
      case (r_owner)
        OWN_ICACHE: mem_a_o = addr_ICACHE_i[ADDR_W-1:0];
        OWN_MEM: begin
          mem_a_o   = addr_MEM_i[ADDR_W-1:0];
          mem_wr_o  = we_MEM_i;
          mem_din_o = data_MEM_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed scenarios followed by a randomized phase. A behavioural
// model (who holds the bus, a shadow copy of RAM contents) predicts every
// output in every cycle; the bench also provides the synchronous RAM itself.
module tb_ram_ctrl;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 1 << ADDR_W;

  // Bus holder as seen by the model.
  localparam int M_NONE  = 0;
  localparam int M_CACHE = 1;
  localparam int M_MEM   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              re_ICACHE_i;
  logic [31:0]       addr_ICACHE_i;
  logic              stl_ICACHE_o;
  logic              re_MEM_i;
  logic              we_MEM_i;
  logic [31:0]       addr_MEM_i;
  logic [7:0]        data_MEM_i;
  logic              stl_MEM_o;
  logic [7:0]        data_RAM_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_din_o;
  logic              mem_wr_o;
  logic [7:0]        mem_dout_i;

  always #5 clk = ~clk;

  ram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .re_ICACHE_i   (re_ICACHE_i),
    .addr_ICACHE_i (addr_ICACHE_i),
    .stl_ICACHE_o  (stl_ICACHE_o),
    .re_MEM_i      (re_MEM_i),
    .we_MEM_i      (we_MEM_i),
    .addr_MEM_i    (addr_MEM_i),
    .data_MEM_i    (data_MEM_i),
    .stl_MEM_o     (stl_MEM_o),
    .data_RAM_o    (data_RAM_o),
    .mem_a_o       (mem_a_o),
    .mem_din_o     (mem_din_o),
    .mem_wr_o      (mem_wr_o),
    .mem_dout_i    (mem_dout_i)
  );

  // Single-port synchronous RAM, read-first, one-cycle read latency.
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    mem_dout_i <= ram[mem_a_o];
    if (mem_wr_o) ram[mem_a_o] <= mem_din_o;
  end

  // Reference model state.
  int                m_owner = M_NONE;
  logic [7:0]        shadow [DEPTH];
  logic [7:0]        m_rd;
  bit                m_rd_ok = 1'b0;
  logic              e_stl_i, e_stl_m, e_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_din;

  // Observations of the last checked cycle.
  logic              o_stl_i, o_stl_m, o_wr;
  logic [ADDR_W-1:0] o_a, o_wr_addr;
  logic [7:0]        o_data;
  int                n_wr_pulse = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Burst / MEM-operation results.
  int         b_i_grant, b_i_last, b_m_grant, b_m_last;
  logic [7:0] b_got [16];
  logic [ADDR_W-1:0] b_addr [16];
  int         mem_stalls;
  logic [7:0] op_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: predict and check outputs at the falling edge, then let
  // the rising edge happen and advance the model.
  task automatic tick();
    bit want_i, want_m;
    @(negedge clk);
    want_i = re_ICACHE_i;
    want_m = re_MEM_i | we_MEM_i;
    e_addr = '0;
    e_wr   = 1'b0;
    e_din  = '0;
    if (rst) begin
      e_stl_i = want_i;
      e_stl_m = want_m;
    end else begin
      e_stl_i = want_i && (m_owner != M_CACHE);
      e_stl_m = want_m && (m_owner != M_MEM);
      if (m_owner == M_CACHE) e_addr = addr_ICACHE_i[ADDR_W-1:0];
      if (m_owner == M_MEM) begin
        e_addr = addr_MEM_i[ADDR_W-1:0];
        e_wr   = we_MEM_i;
        e_din  = data_MEM_i;
      end
    end
    check("stl_icache", stl_ICACHE_o, e_stl_i);
    check("stl_mem", stl_MEM_o, e_stl_m);
    check("mem_a", mem_a_o, e_addr);
    check("mem_wr", mem_wr_o, e_wr);
    if (e_wr) check("mem_din", mem_din_o, e_din);
    if (m_rd_ok) check("data_ram", data_RAM_o, m_rd);
    if (want_i && want_m) check("never_both_granted", stl_ICACHE_o | stl_MEM_o, 1);
    o_stl_i = stl_ICACHE_o;
    o_stl_m = stl_MEM_o;
    o_wr    = mem_wr_o;
    o_a     = mem_a_o;
    o_data  = data_RAM_o;
    if (o_wr === 1'b1) begin
      n_wr_pulse++;
      o_wr_addr = mem_a_o;
    end
    @(posedge clk);
    m_rd    = shadow[e_addr];
    m_rd_ok = 1'b1;
    if (e_wr) shadow[e_addr] = e_din;
    if (rst) begin
      m_owner = M_NONE;
    end else if (!((m_owner == M_CACHE && want_i) || (m_owner == M_MEM && want_m))) begin
      m_owner = want_m ? M_MEM : (want_i ? M_CACHE : M_NONE);
    end
    cyc++;
    #1;
  endtask

  // Cache line fill of 16 bytes with an optional MEM requester that raises its
  // request at burst cycle mem_start and drops it after mem_len granted cycles.
  // rst_at >= 0 pulses reset when the cache is about to present that byte.
  task automatic burst(input logic [31:0] base, input int mem_start, input int mem_len,
                       input bit mem_we, input logic [31:0] maddr, input logic [7:0] mdata,
                       input int rst_at);
    int cnt = 0, mdone = 0, t = 0, prev = -1;
    bit mact, did_rst = 1'b0;
    b_i_grant = -1; b_i_last = -1; b_m_grant = -1; b_m_last = -1;
    for (int i = 0; i < 16; i++) begin
      b_got[i]  = 'x;
      b_addr[i] = 'x;
    end
    while (((cnt < 17) || (mem_start >= 0 && mdone < mem_len)) && t < 200) begin
      mact          = (mem_start >= 0) && (t >= mem_start) && (mdone < mem_len);
      re_ICACHE_i   = (cnt < 17);
      addr_ICACHE_i = base + cnt;
      re_MEM_i      = mact && !mem_we;
      we_MEM_i      = mact && mem_we;
      addr_MEM_i    = maddr;
      data_MEM_i    = mdata;
      rst           = !did_rst && (rst_at >= 0) && (cnt == rst_at);
      tick();
      if (prev >= 0 && prev < 16) b_got[prev] = o_data;
      prev = -1;
      if (re_ICACHE_i) begin
        b_i_last = t;
        if (!o_stl_i && !rst) begin
          if (b_i_grant < 0) b_i_grant = t;
          if (cnt < 16) b_addr[cnt] = o_a;
          prev = cnt;
          cnt++;
        end
      end
      if (mact) begin
        b_m_last = t;
        if (!o_stl_m && !rst) begin
          if (b_m_grant < 0) b_m_grant = t;
          mdone++;
        end
      end
      if (rst) begin
        did_rst = 1'b1;
        rst     = 1'b0;
        break;
      end
      t++;
    end
    check("burst_cycle_bound", (t < 200), 1);
    re_ICACHE_i = 1'b0;
    re_MEM_i    = 1'b0;
    we_MEM_i    = 1'b0;
  endtask

  // Single MEM-stage access: hold the request until granted, then drop it.
  // op_data holds data_RAM_o of the cycle after the granted one.
  task automatic mem_op(input bit w, input logic [31:0] a, input logic [7:0] d);
    int n = 0;
    re_MEM_i   = !w;
    we_MEM_i   = w;
    addr_MEM_i = a;
    data_MEM_i = d;
    mem_stalls = 0;
    do begin
      tick();
      if (o_stl_m) mem_stalls++;
      n++;
    end while (o_stl_m && n < 20);
    check("mem_grant_bound", o_stl_m, 0);
    re_MEM_i = 1'b0;
    we_MEM_i = 1'b0;
    tick();
    op_data = o_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    bit ri, rm, mw;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = i[7:0];
      shadow[i] = i[7:0];
    end
    rst = 1'b1; re_ICACHE_i = 1'b1; addr_ICACHE_i = 32'h0000_0120;
    re_MEM_i = 1'b0; we_MEM_i = 1'b0; addr_MEM_i = '0; data_MEM_i = '0;

    // Reset held two cycles with the cache requesting.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_stl_icache", o_stl_i, 1);
      check("rst_mem_wr", o_wr, 0);
      check("rst_mem_a", o_a, 0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_still_stalled", o_stl_i, 1);
    tick();
    check("post_rst_granted", o_stl_i, 0);
    re_ICACHE_i = 1'b0;
    tick();

    // Cache fill of 0x00120: one stall cycle, then gapless addresses and data.
    burst(32'h0000_0120, -1, 0, 1'b0, '0, '0, -1);
    check("fill_grant_cycle", b_i_grant, 1);
    for (int i = 0; i < 16; i++) begin
      check("fill_addr", b_addr[i], 32'h120 + i);
      check("fill_byte", b_got[i], 32'h20 + i);
    end
    tick();

    // MEM write 0xA5 to 0x10004, then read it back.
    wr_before = n_wr_pulse;
    mem_op(1'b1, 32'h0001_0004, 8'hA5);
    check("wr_stall_cycles", mem_stalls, 1);
    check("wr_pulse_count", n_wr_pulse - wr_before, 1);
    check("wr_addr", o_wr_addr, 32'h10004);
    mem_op(1'b0, 32'h0001_0004, 8'h00);
    check("rd_back", op_data, 32'hA5);
    tick();

    // Contention: both rise together, MEM wins and keeps three cycles.
    burst(32'h0000_0340, 0, 3, 1'b0, 32'h0001_0004, 8'h00, -1);
    check("contend_mem_grant", b_m_grant, 1);
    check("contend_cache_grant", b_i_grant, b_m_last + 2);
    for (int i = 0; i < 16; i++) check("contend_byte", b_got[i], 32'h40 + i);
    tick();

    // No preemption: MEM writes mid-burst; upper address bits are dropped.
    burst(32'hABC1_FFF0, 5, 2, 1'b1, 32'h0000_0500, 8'h3C, -1);
    check("nopreempt_mem_grant", b_m_grant, b_i_last + 2);
    for (int i = 0; i < 16; i++) begin
      check("nopreempt_addr", b_addr[i], 32'h1FFF0 + i);
      check("nopreempt_byte", b_got[i], 32'hF0 + i);
    end
    mem_op(1'b0, 32'h0000_0500, 8'h00);
    check("nopreempt_wr_data", op_data, 32'h3C);
    tick();

    // Reset at byte 7 of a burst, then a fresh burst completes.
    wr_before = n_wr_pulse;
    burst(32'h0000_0780, -1, 0, 1'b0, '0, '0, 7);
    check("rst_burst_bytes_before", b_got[6], 32'h86);
    re_ICACHE_i = 1'b1;
    addr_ICACHE_i = 32'h0000_0787;
    tick();
    check("rst_burst_owner_idle", o_stl_i, 1);
    re_ICACHE_i = 1'b0;
    tick();
    check("rst_burst_no_wr", n_wr_pulse - wr_before, 0);
    burst(32'h0000_0780, -1, 0, 1'b0, '0, '0, -1);
    for (int i = 0; i < 16; i++) check("rst_burst_refill", b_got[i], 32'h80 + i);
    tick();

    // Randomized phase: requests held for random lengths, random addresses and
    // data, occasional reset; every cycle is checked against the model.
    ri = 1'b0; rm = 1'b0; mw = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) ri = !ri;
      if ($urandom_range(0, 4) == 0) begin
        rm = !rm;
        mw = $urandom_range(0, 1) == 1;
      end
      rst           = ($urandom_range(0, 60) == 0);
      re_ICACHE_i   = ri;
      addr_ICACHE_i = $urandom;
      re_MEM_i      = rm && !mw;
      we_MEM_i      = rm && mw;
      addr_MEM_i    = {$urandom_range(0, 65535), 11'h0, 5'($urandom_range(0, 31))};
      data_MEM_i    = 8'($urandom);
      tick();
    end
    rst = 1'b0; re_ICACHE_i = 1'b0; re_MEM_i = 1'b0; we_MEM_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Byte-wide memory controller and arbiter that answers the instruction cache's line-fill requests and the MEM stage's byte loads/stores. It owns the single-port synchronous RAM (one-cycle read latency), grants the bus to one requester at a time, and stalls the other. Once a requester is granted, it keeps the bus until it drops its request, so a cache line fill is never preempted.

## Interface
- ADDR_W, 17: RAM address width; request addresses are truncated to `[ADDR_W-1:0]`.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- re_ICACHE_i  in  1  instruction-cache read request; held for the whole burst.
- addr_ICACHE_i  in  32  cache byte address; changes every cycle during a burst.
- stl_ICACHE_o  out  1  stall to the cache; combinational.
- re_MEM_i  in  1  MEM-stage read request.
- we_MEM_i  in  1  MEM-stage write request; `re_MEM_i` and `we_MEM_i` are never both 1.
- addr_MEM_i  in  32  MEM-stage byte address.
- data_MEM_i  in  8  MEM-stage write byte.
- stl_MEM_o  out  1  stall to MEM; combinational.
- data_RAM_o  out  8  read byte, broadcast to both requesters; equals `mem_dout_i`.
- mem_a_o  out  ADDR_W  RAM address; combinational.
- mem_din_o  out  8  RAM write data.
- mem_wr_o  out  1  RAM write strobe.
- mem_dout_i  in  8  RAM read data for the address presented in the previous cycle.

## Operation
- Owner register holds one of three values: `OWN_IDLE`, `OWN_ICACHE`, `OWN_MEM`.
  - Reset value is `OWN_IDLE`.
- Request signals:
  - `req_I = re_ICACHE_i`.
  - `req_M = re_MEM_i | we_MEM_i`.
- Next-owner rule, evaluated every cycle:
  - **Current owner's request still high:** owner is unchanged. This is the lock; there is no preemption.
  - **Owner is `OWN_IDLE`, or the current owner's request is low:** re-arbitrate. `req_M` has priority (MEM is older in the pipeline), then `req_I`, otherwise `OWN_IDLE`.
- Stalls are computed from the registered owner only:
  - `stl_ICACHE_o = req_I & (owner != OWN_ICACHE)`.
  - `stl_MEM_o = req_M & (owner != OWN_MEM)`.
  - A newly arriving request is therefore stalled for at least one cycle.
- RAM drive:
  - **`owner == OWN_ICACHE`:** `mem_a_o = addr_ICACHE_i[ADDR_W-1:0]` and `mem_wr_o = 0`.
  - **`owner == OWN_MEM`:** `mem_a_o = addr_MEM_i[ADDR_W-1:0]`, `mem_wr_o = we_MEM_i`, `mem_din_o = data_MEM_i`.
  - **`owner == OWN_IDLE`:** `mem_a_o = 0`, `mem_wr_o = 0`, `mem_din_o = 0`.
- Handoff:
  - If the owner drops its request while the other side is requesting, the other side becomes owner at the next edge.
  - Its stall drops in that next cycle; there is no idle bubble.
- Reset:
  - During `rst`, `mem_wr_o = 0` and `mem_a_o = 0`.
  - Each stall output equals its request, so requesters hold.
  - Reset mid-burst aborts the burst; owner is `OWN_IDLE` after the reset edge.
- Invariants:
  - `mem_wr_o` is never 1 unless the owner is `OWN_MEM`.
  - Both stall outputs are never 0 while both requests are high.

## Timing
- **Grant latency:** a request first seen high in cycle n while the owner is idle is stalled in cycle n. The owner updates at the n/n+1 edge, and the stall is 0 from cycle n+1.
- **Read latency:** the address presented in cycle k returns on `data_RAM_o` in cycle k+1.
  - A cache burst presents `base`, `base+1`, …, `base+15` in consecutive unstalled cycles.
  - It receives each byte one cycle later.
  - The cache keeps `re_ICACHE_i` high through the cycle in which it samples the last byte; the controller does not count bytes.
- **Write:** the byte is committed at the end of the first unstalled cycle in which `we_MEM_i` is high.
- **Release:** the owner's request is low in cycle r. Re-arbitration happens in cycle r, and the new owner is effective in r+1.
- **Simultaneous first requests from both sides:** MEM wins. ICACHE stays stalled until MEM drops its request.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `re_ICACHE_i = 1` -> `stl_ICACHE_o = 1`, `mem_wr_o = 0`, `mem_a_o = 0`. First cycle after reset: owner is `OWN_IDLE` and the stall is still 1. Second cycle: stall is 0.
- **Cache fill:** cache requests base `0x00120`; RAM is preloaded with byte value = address low byte -> stall for 1 cycle, then `mem_a_o` steps `0x120` through `0x12F`. `data_RAM_o` returns `0x20` through `0x2F` one cycle later, with no gaps.
- **MEM write:** write `0xA5` to `0x1_0004` -> one stall cycle, then `mem_wr_o = 1` for exactly one cycle with `mem_a_o = 0x10004`. A following read of `0x10004` returns `0xA5`.
- **Contention:** both requests rise in the same cycle -> MEM is granted and ICACHE stays stalled. On the cycle after MEM drops its request, `stl_ICACHE_o = 0` and `mem_a_o` tracks the cache address.
- **No preemption:** MEM requests in the middle of a cache burst -> `stl_MEM_o = 1` until the cycle after `re_ICACHE_i` falls, and all 16 cache bytes are correct.
- **Reset mid-burst:** assert `rst` at byte 7 of a cache burst -> owner is `OWN_IDLE` after the reset edge and `mem_wr_o` never pulses. A new burst afterwards completes with correct data.
